throttle_sequencer: RTL and testbench
=====================================

THROTTLE_SEQUENCER -- requirements
Module: throttle_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000: clk cycles per ramp tick; legal range 2..2^24.
REQ-002 Parameter STEP, default 2: maximum throttle change per tick; legal range 1..255.
REQ-003 Parameter ARM_TICKS, default 200: ticks held at zero throttle while arming; legal range 1..65535.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 arm  in  1  level; 1 = request armed operation, 0 = request disarm.
REQ-007 cmd_valid  in  1  target throttle command valid.
REQ-008 cmd_thr  in  8  target throttle, 0..255.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-010 estop  in  1  emergency stop; present only with THR_ESTOP_EN.
REQ-011 thr  out  8  throttle to the ESC driver throttle input.
REQ-012 esc_en  out  1  ESC driver enable.
REQ-013 state  out  2  current state: IDLE=0, ARMING=1, RUN=2, STOP=3.
REQ-014 at_target  out  1  1 when state==RUN and thr==target.

Function
REQ-015 Tick: free-running counter SHALL emit a 1-cycle tick every TICK_DIV clk cycles; first tick TICK_DIV cycles after reset release.
REQ-016 IDLE: thr=0, esc_en=0, cmd_ready=0; arm==1 -> ARMING next cycle, arm tick count cleared.
REQ-017 ARMING: esc_en=1, thr=0, cmd_ready=0; count ticks; on the ARM_TICKS-th tick -> RUN with target=0; arm==0 -> IDLE next cycle, count discarded.
REQ-018 RUN: esc_en=1, cmd_ready=1; accepted cmd_thr SHALL load target on the following edge; arm==0 -> STOP.
REQ-019 Ramp on each tick in RUN/STOP: thr<target -> thr=min(thr+STEP,target); thr>target -> thr=max(thr-STEP,target); arithmetic in 9 bits, no wrap at 0 or 255.
REQ-020 Same-cycle command accept and tick: ramp step uses old target; new target applies from the next tick.
REQ-021 STOP: cmd_ready=0, target forced 0, esc_en=1; ramp down per REQ-019; tick producing thr==0 -> IDLE next cycle; arm reassertion ignored until IDLE.
REQ-022 All outputs SHALL be registered; thr changes only on tick edges, reset, or estop.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, thr=0, target=0, esc_en=0, cmd_ready=0, at_target=0, tick and arm counters=0, in any state.
REQ-024 Reset release mid-stream: operation SHALL restart from IDLE; a held arm=1 re-enters ARMING and re-counts ARM_TICKS fully.

Configuration
REQ-025 Macro THR_ESTOP_EN defined: estop port present; estop==1 in any state -> next edge state=IDLE, thr=0, esc_en=0, target=0; held estop keeps IDLE regardless of arm.
REQ-026 Macro undefined: estop port absent, behaviour identical to estop tied 0.

Structure
REQ-027 Shared package SHALL hold the state encoding constants (IDLE/ARMING/RUN/STOP) and the 8-bit throttle width constant.
REQ-028 Sub-module ramp_tick SHALL implement the TICK_DIV divider (clk, rst_n, tick out); sequencer FSM and ramp arithmetic stay in throttle_sequencer.

Verification (TICK_DIV=4, STEP=2, ARM_TICKS=3 unless stated)
REQ-029 Arm: arm=1 from IDLE -> state=1, esc_en=1, thr=0 for 3 ticks (12 cycles), then state=2, cmd_ready=1.
REQ-030 Ramp up: in RUN accept cmd_thr=9 -> thr 2,4,6,8,9 on successive ticks; at_target=1 after 9.
REQ-031 Ramp down: thr=9, accept cmd_thr=0 -> thr 7,5,3,1,0, no underflow; STEP=255 with thr=200, target 10 -> thr=10 in one tick.
REQ-032 Disarm: arm=0 at thr=6 -> state=3, cmd_ready=0, thr 4,2,0 then state=0, esc_en=0; arm pulsed during STOP ignored.
REQ-033 Reset: rst_n low mid-RUN at thr=50 -> thr=0, esc_en=0, state=0 without waiting for a clk edge.
REQ-034 With THR_ESTOP_EN: estop=1 at thr=200 in RUN -> next edge thr=0, state=0, esc_en=0; without macro, build elaborates with no estop port.

Source files
------------

// File: rtl/throttle_sequencer_pkg.sv
// throttle_sequencer_pkg
// Shared definitions for the throttle sequencer: state encoding, throttle
// width and the saturating ramp-step helper used by the sequencer datapath.
package throttle_sequencer_pkg;

  localparam int THR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_RUN    = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // Move thr one step towards tgt without overshooting it. The 9-bit
  // intermediates keep the sum/difference from wrapping at 255 or 0.
  function automatic logic [THR_W-1:0] ramp_next(input logic [THR_W-1:0] thr,
                                                 input logic [THR_W-1:0] tgt,
                                                 input logic [THR_W-1:0] step);
    logic [THR_W:0]   up_s;
    logic [THR_W:0]   dn_s;
    logic [THR_W-1:0] res_s;
    up_s = {1'b0, thr} + {1'b0, step};
    dn_s = {1'b0, thr} - {1'b0, step};
    if (thr < tgt) begin
      if (up_s > {1'b0, tgt}) res_s = tgt;
      else                    res_s = up_s[THR_W-1:0];
    end else if (thr > tgt) begin
      // dn_s[THR_W] set means the subtraction borrowed below zero
      if (dn_s[THR_W] || (dn_s < {1'b0, tgt})) res_s = tgt;
      else                                     res_s = dn_s[THR_W-1:0];
    end else begin
      res_s = thr;
    end
    return res_s;
  endfunction

endpackage

// File: rtl/throttle_sequencer_if.sv
// throttle_sequencer_if
// Bundles the arm/command handshake and the ESC-facing status outputs.
//   master : controller side (drives arm, cmd_valid, cmd_thr)
//   slave  : sequencer side (drives cmd_ready, thr, esc_en, state, at_target)
interface throttle_sequencer_if;
  import throttle_sequencer_pkg::*;

  logic             arm;
  logic             cmd_valid;
  logic [THR_W-1:0] cmd_thr;
  logic             cmd_ready;
  logic [THR_W-1:0] thr;
  logic             esc_en;
  logic [1:0]       state;
  logic             at_target;

  modport master (
    output arm, cmd_valid, cmd_thr,
    input  cmd_ready, thr, esc_en, state, at_target
  );

  modport slave (
    input  arm, cmd_valid, cmd_thr,
    output cmd_ready, thr, esc_en, state, at_target
  );

endinterface

// File: rtl/throttle_sequencer_ramp_tick.sv
// ramp_tick
// Free-running divider producing a registered one-cycle tick every TICK_DIV
// clocks; the first tick is seen by the clk edge TICK_DIV cycles after reset
// release.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse
module ramp_tick #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [23:0] CNT_LAST = 24'(TICK_DIV - 1);
  // tick is registered, so it is raised one count early to land on the
  // TICK_DIV-th edge
  localparam logic [23:0] CNT_PRE  = 24'(TICK_DIV - 2);

  logic [23:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;

  // next count and tick
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) cnt_d = 24'd0;
    else                   cnt_d = cnt_q + 24'd1;
    if (cnt_q == CNT_PRE)  tick_d = 1'b1;
    else                   tick_d = 1'b0;
  end

  // divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 24'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/throttle_sequencer.sv
// throttle_sequencer
// Arming/run/stop sequencer for an ESC throttle with per-tick slew limiting.
//   clk, rst_n : clock, asynchronous active-low reset
//   estop      : emergency stop (only when THR_ESTOP_EN is defined)
//   bus        : throttle_sequencer_if.slave (arm, command handshake,
//                thr, esc_en, state, at_target)
// Optional feature macro: THR_ESTOP_EN adds the estop input.
import throttle_sequencer_pkg::*;

module throttle_sequencer #(
  parameter int TICK_DIV  = 100000,
  parameter int STEP      = 2,
  parameter int ARM_TICKS = 200
) (
  input  logic clk,
  input  logic rst_n,
`ifdef THR_ESTOP_EN
  input  logic estop,
`endif
  throttle_sequencer_if.slave bus
);

  localparam logic [THR_W-1:0] STEP_C   = THR_W'(STEP);
  localparam logic [15:0]      ARM_LAST = 16'(ARM_TICKS - 1);

  state_e           state_q, state_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic [THR_W-1:0] target_q, target_d;
  logic [15:0]      arm_cnt_q, arm_cnt_d;
  logic             esc_en_q, esc_en_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             at_target_q, at_target_d;
  logic             tick_s;
  logic [THR_W-1:0] ramp_s;

  ramp_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_s)
  );

  // sequencer next state, ramp and registered-output next values
  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    target_d  = target_q;
    arm_cnt_d = arm_cnt_q;
    // ramp always uses the current target, so a command accepted on a tick
    // edge only takes effect from the following tick
    ramp_s    = ramp_next(thr_q, target_q, STEP_C);

    case (state_q)
      ST_IDLE: begin
        thr_d     = 8'd0;
        target_d  = 8'd0;
        arm_cnt_d = 16'd0;
        if (bus.arm) state_d = ST_ARMING;
        else         state_d = ST_IDLE;
      end
      ST_ARMING: begin
        thr_d    = 8'd0;
        target_d = 8'd0;
        if (!bus.arm) begin
          state_d   = ST_IDLE;
          arm_cnt_d = 16'd0;
        end else if (tick_s) begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d   = ST_RUN;
            arm_cnt_d = 16'd0;
          end else begin
            arm_cnt_d = arm_cnt_q + 16'd1;
          end
        end else begin
          state_d = ST_ARMING;
        end
      end
      ST_RUN: begin
        if (tick_s) thr_d = ramp_s;
        else        thr_d = thr_q;
        if (!bus.arm) begin
          state_d  = ST_STOP;
          target_d = 8'd0;
        end else if (bus.cmd_valid && cmd_ready_q) begin
          target_d = bus.cmd_thr;
        end else begin
          target_d = target_q;
        end
      end
      ST_STOP: begin
        target_d = 8'd0;
        if (tick_s) begin
          thr_d = ramp_s;
          if (ramp_s == 8'd0) state_d = ST_IDLE;
          else                state_d = ST_STOP;
        end else begin
          thr_d = thr_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        thr_d     = 8'd0;
        target_d  = 8'd0;
        arm_cnt_d = 16'd0;
      end
    endcase

`ifdef THR_ESTOP_EN
    if (estop) begin
      state_d   = ST_IDLE;
      thr_d     = 8'd0;
      target_d  = 8'd0;
      arm_cnt_d = 16'd0;
    end else begin
      state_d   = state_d;
    end
`endif

    // outputs are computed from next state so they stay registered yet
    // line up with state/thr in the same cycle
    esc_en_d    = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_RUN);
    at_target_d = (state_d == ST_RUN) && (thr_d == target_d);
  end

  // sequencer state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      thr_q       <= 8'd0;
      target_q    <= 8'd0;
      arm_cnt_q   <= 16'd0;
      esc_en_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      target_q    <= target_d;
      arm_cnt_q   <= arm_cnt_d;
      esc_en_q    <= esc_en_d;
      cmd_ready_q <= cmd_ready_d;
      at_target_q <= at_target_d;
    end
  end

  assign bus.thr       = thr_q;
  assign bus.esc_en    = esc_en_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.state     = state_q;
  assign bus.at_target = at_target_q;

endmodule

// File: tb/tb_throttle_sequencer.sv
// tb_throttle_sequencer
// Self-checking bench: TICK_DIV=4, STEP=2, ARM_TICKS=3 on u_dut and STEP=255
// on u_dut2. Expected throttle sequences are queued when a command is driven
// and popped as each throttle change appears.
module tb_throttle_sequencer;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef THR_ESTOP_EN
  logic estop = 1'b0;
`endif

  throttle_sequencer_if bus();
  throttle_sequencer_if bus2();

  throttle_sequencer #(.TICK_DIV(TD), .STEP(2), .ARM_TICKS(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef THR_ESTOP_EN
    .estop (estop),
`endif
    .bus   (bus)
  );

  throttle_sequencer #(.TICK_DIV(TD), .STEP(255), .ARM_TICKS(3)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef THR_ESTOP_EN
    .estop (estop),
`endif
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  task automatic wait_thr_change(input bit sel, input int budget, output int cycles, output bit ok);
    logic [7:0] prev;
    prev = sel ? bus2.thr : bus.thr;
    ok = 1'b0;
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if ((sel ? bus2.thr : bus.thr) !== prev) ok = 1'b1;
    end
  endtask

  task automatic wait_state(input bit sel, input logic [1:0] s, input int budget, output int cycles, output bit ok);
    ok = ((sel ? bus2.state : bus.state) === s);
    cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if ((sel ? bus2.state : bus.state) === s) ok = 1'b1;
    end
  endtask

  task automatic send_cmd(input bit sel, input logic [7:0] v);
    if (sel) begin bus2.cmd_valid = 1'b1; bus2.cmd_thr = v; end
    else     begin bus.cmd_valid  = 1'b1; bus.cmd_thr  = v; end
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus2.cmd_valid = 1'b0;
  endtask

  // pop and compare queued throttle values on u_dut, also checking tick spacing
  task automatic drain_main(input string tag, input logic [7:0] final_thr);
    int cyc;
    bit ok;
    logic [7:0] e;
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      wait_thr_change(1'b0, 3 * TD, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s_timeout[%0d]: thr stuck at %0d, required %0d", tag, i, bus.thr, e);
      end else if (bus.thr !== e) begin
        errors++;
        $display("FAIL %s_thr[%0d]: got %0d, required %0d", tag, i, bus.thr, e);
      end
      if (i > 0) begin
        checks++;
        if (cyc !== TD) begin
          errors++;
          $display("FAIL %s_interval[%0d]: got %0d cycles, required %0d", tag, i, cyc, TD);
        end
      end
      checks++;
      if (bus.at_target !== (e == final_thr)) begin
        errors++;
        $display("FAIL %s_at_target[%0d]: got %0b, required %0b", tag, i, bus.at_target, (e == final_thr));
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", bus.state); end
    checks++; if (bus.thr !== 8'd0) begin errors++; $display("FAIL rst_thr: got %0d, required 0", bus.thr); end
    checks++; if (bus.esc_en !== 1'b0) begin errors++; $display("FAIL rst_esc_en: got %0b, required 0", bus.esc_en); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b, required 0", bus.cmd_ready); end
    checks++; if (bus.at_target !== 1'b0) begin errors++; $display("FAIL rst_at_target: got %0b, required 0", bus.at_target); end
  endtask

  task automatic test_arm_abort();
    @(negedge clk);
    rst_n = 1'b1;
    bus.arm = 1'b1;
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL abort_enter: got state %0d, required 1", bus.state); end
    repeat (5) @(negedge clk);
    bus.arm = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL abort_idle: got state %0d, required 0", bus.state); end
    checks++; if (bus.esc_en !== 1'b0) begin errors++; $display("FAIL abort_esc_en: got %0b, required 0", bus.esc_en); end
  endtask

  // count cycles spent in ARMING after arm is asserted; three ticks of four
  // cycles must elapse, i.e. 9..12 samples depending on tick phase
  task automatic test_arm(input string tag);
    int n;
    bit thr_bad;
    bus.arm = 1'b1;
    @(negedge clk);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL %s_state: got %0d, required 1", tag, bus.state); end
    checks++; if (bus.esc_en !== 1'b1) begin errors++; $display("FAIL %s_esc_en: got %0b, required 1", tag, bus.esc_en); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL %s_cmd_ready: got %0b, required 0", tag, bus.cmd_ready); end
    n = 1;
    thr_bad = 1'b0;
    while (bus.state === 2'd1 && n < 40) begin
      if (bus.thr !== 8'd0) thr_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    n--;
    checks++; if (thr_bad) begin errors++; $display("FAIL %s_thr_zero: got nonzero thr, required 0", tag); end
    checks++; if (n < 2 * TD + 1 || n > 3 * TD) begin errors++; $display("FAIL %s_duration: got %0d cycles, required %0d..%0d", tag, n, 2 * TD + 1, 3 * TD); end
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL %s_run: got state %0d, required 2", tag, bus.state); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_run_ready: got %0b, required 1", tag, bus.cmd_ready); end
    checks++; if (bus.at_target !== 1'b1) begin errors++; $display("FAIL %s_run_at_target: got %0b, required 1", tag, bus.at_target); end
  endtask

  task automatic test_ramp_up();
    send_cmd(1'b0, 8'd9);
    exp_q.push_back(8'd2); exp_q.push_back(8'd4); exp_q.push_back(8'd6);
    exp_q.push_back(8'd8); exp_q.push_back(8'd9);
    drain_main("up", 8'd9);
    repeat (2 * TD) @(negedge clk);
    checks++; if (bus.thr !== 8'd9) begin errors++; $display("FAIL up_hold: got %0d, required 9", bus.thr); end
  endtask

  task automatic test_ramp_down();
    send_cmd(1'b0, 8'd0);
    exp_q.push_back(8'd7); exp_q.push_back(8'd5); exp_q.push_back(8'd3);
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    drain_main("down", 8'd0);
    repeat (2 * TD) @(negedge clk);
    checks++; if (bus.thr !== 8'd0) begin errors++; $display("FAIL down_hold: got %0d, required 0", bus.thr); end
  endtask

  task automatic test_disarm();
    int cyc;
    bit ok;
    logic [7:0] e;
    send_cmd(1'b0, 8'd6);
    exp_q.push_back(8'd2); exp_q.push_back(8'd4); exp_q.push_back(8'd6);
    drain_main("pre_disarm", 8'd6);
    bus.arm = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL disarm_state: got %0d, required 3", bus.state); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL disarm_ready: got %0b, required 0", bus.cmd_ready); end
    checks++; if (bus.esc_en !== 1'b1) begin errors++; $display("FAIL disarm_esc_en: got %0b, required 1", bus.esc_en); end
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL disarm_arm_pulse: got state %0d, required 3", bus.state); end
    exp_q.push_back(8'd4); exp_q.push_back(8'd2); exp_q.push_back(8'd0);
    for (int i = 0; i < 3; i++) begin
      wait_thr_change(1'b0, 3 * TD, cyc, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || bus.thr !== e) begin
        errors++;
        $display("FAIL stop_thr[%0d]: got %0d, required %0d", i, bus.thr, e);
      end
    end
    wait_state(1'b0, 2'd0, 2, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_idle: got state %0d, required 0", bus.state); end
    checks++; if (bus.esc_en !== 1'b0) begin errors++; $display("FAIL stop_esc_en: got %0b, required 0", bus.esc_en); end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit ok;
    bus.arm = 1'b1;
    wait_state(1'b0, 2'd2, 40, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_run_reach: got state %0d, required 2", bus.state); end
    send_cmd(1'b0, 8'd50);
    cyc = 0;
    while (bus.thr !== 8'd50 && cyc < 40 * TD) begin @(negedge clk); cyc++; end
    checks++; if (bus.thr !== 8'd50) begin errors++; $display("FAIL mid_thr50: got %0d, required 50", bus.thr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.thr !== 8'd0) begin errors++; $display("FAIL mid_rst_thr: got %0d, required 0", bus.thr); end
    checks++; if (bus.esc_en !== 1'b0) begin errors++; $display("FAIL mid_rst_esc_en: got %0b, required 0", bus.esc_en); end
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d, required 0", bus.state); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %0b, required 0", bus.cmd_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_arm("rearm");
  endtask

  task automatic test_step255();
    int cyc;
    bit ok;
    logic [7:0] e;
    bus2.arm = 1'b1;
    wait_state(1'b1, 2'd2, 40, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL big_run: got state %0d, required 2", bus2.state); end
    send_cmd(1'b1, 8'd200);
    exp_q.push_back(8'd200);
    wait_thr_change(1'b1, 2 * TD, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus2.thr !== e) begin errors++; $display("FAIL big_up: got %0d, required %0d", bus2.thr, e); end
    send_cmd(1'b1, 8'd10);
    exp_q.push_back(8'd10);
    wait_thr_change(1'b1, 2 * TD, cyc, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || bus2.thr !== e) begin errors++; $display("FAIL big_down: got %0d, required %0d", bus2.thr, e); end
    checks++; if (bus2.at_target !== 1'b1) begin errors++; $display("FAIL big_at_target: got %0b, required 1", bus2.at_target); end
  endtask

`ifdef THR_ESTOP_EN
  task automatic test_estop();
    int cyc;
    bit ok;
    send_cmd(1'b1, 8'd200);
    wait_thr_change(1'b1, 2 * TD, cyc, ok);
    checks++; if (!ok || bus2.thr !== 8'd200) begin errors++; $display("FAIL estop_pre: got %0d, required 200", bus2.thr); end
    estop = 1'b1;
    @(negedge clk);
    checks++; if (bus2.thr !== 8'd0) begin errors++; $display("FAIL estop_thr: got %0d, required 0", bus2.thr); end
    checks++; if (bus2.state !== 2'd0) begin errors++; $display("FAIL estop_state: got %0d, required 0", bus2.state); end
    checks++; if (bus2.esc_en !== 1'b0) begin errors++; $display("FAIL estop_esc_en: got %0b, required 0", bus2.esc_en); end
    repeat (2 * TD) @(negedge clk);
    checks++; if (bus2.state !== 2'd0) begin errors++; $display("FAIL estop_hold: got state %0d, required 0", bus2.state); end
    estop = 1'b0;
    @(negedge clk);
    checks++; if (bus2.state !== 2'd1) begin errors++; $display("FAIL estop_rearm: got state %0d, required 1", bus2.state); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arm = 1'b0;  bus.cmd_valid = 1'b0;  bus.cmd_thr = 8'd0;
    bus2.arm = 1'b0; bus2.cmd_valid = 1'b0; bus2.cmd_thr = 8'd0;
    test_reset();
    test_arm_abort();
    test_arm("arm");
    test_ramp_up();
    test_ramp_down();
    test_disarm();
    test_reset_midrun();
    test_step255();
`ifdef THR_ESTOP_EN
    test_estop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
